// File: rtl/risc_ctrl.sv
// risc_ctrl: eight-phase instruction sequencer with stopped/halted run states.
// Phase states encode as 0..7 so the phase number is just the low state bits.
module risc_ctrl #(
  parameter bit AUTO_START = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_acc,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic       busy,
  output logic [2:0] phase
);
  typedef enum logic [3:0] {P0, P1, P2, P3, P4, P5, P6, P7, STOPPED, HALTED} state_e;
  state_e state_q, state_d;
  logic hlt, skz, jmp, sto, aluop, late;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= STOPPED;
    else     state_q <= state_d;
  always_comb begin
    hlt    = opcode == 3'b000;
    skz    = opcode == 3'b001;
    sto    = opcode == 3'b110;
    jmp    = opcode == 3'b111;
    aluop  = opcode inside {3'b010, 3'b011, 3'b100, 3'b101};
    state_d = state_q == STOPPED ? ((start || AUTO_START) ? P0 : STOPPED) :
              state_q == HALTED  ? (start ? P0 : HALTED) :
              state_q == P7      ? P0 :
              (state_q == P4 && hlt) ? HALTED : state_e'(state_q + 4'd1);
    busy   = ~state_q[3];
    phase  = busy ? state_q[2:0] : 3'd0;
    late   = state_q inside {P6, P7};
    sel    = busy && !state_q[2];
    rd     = state_q inside {P1, P2, P3} || (aluop && state_q inside {P5, P6, P7});
    ld_ir  = state_q inside {P2, P3};
    inc_pc = state_q == P4 || (state_q == P6 && skz && zero);
    ld_pc  = late && jmp;
    ld_acc = state_q == P7 && aluop;
    wr     = state_q == P7 && sto;
    data_e = late && sto;
    halt   = state_q == HALTED || (state_q == P4 && hlt);
  end
endmodule

// File: tb/tb_risc_ctrl.sv
// tb_risc_ctrl: directed sequences with a queued expected-output scoreboard.
module tb_risc_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, zero = 1'b0, probe = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic sel, rd, ld_ir, inc_pc, ld_pc, ld_acc, wr, data_e, halt, busy;
  logic [2:0] phase;
  logic [12:0] got, exp_v;
  string exp_n;
  logic [12:0] vq[$];
  string nq[$];
  int checks = 0, errors = 0;
  localparam int BUSY = 12, HALT = 8, SEL = 7, RD = 6, LDIR = 5, INC = 4, LDPC = 3, LDA = 2, WR = 1, DE = 0;

  risc_ctrl #(.AUTO_START(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_acc(ld_acc), .wr(wr), .data_e(data_e), .halt(halt), .busy(busy), .phase(phase)
  );

  always #5 clk = ~clk;
  assign got = {busy, phase, halt, sel, rd, ld_ir, inc_pc, ld_pc, ld_acc, wr, data_e};

  // st: 0..7 = phase, 8 = stopped, 9 = halted
  function automatic logic [12:0] ev(input logic [3:0] st, input logic [2:0] op, input logic z);
    logic [12:0] r;
    logic alu;
    r = '0;
    alu = op inside {3'd2, 3'd3, 3'd4, 3'd5};
    case (st)
      4'd0: r[SEL] = 1'b1;
      4'd1: begin r[SEL] = 1'b1; r[RD] = 1'b1; end
      4'd2, 4'd3: begin r[SEL] = 1'b1; r[RD] = 1'b1; r[LDIR] = 1'b1; end
      4'd4: begin r[INC] = 1'b1; r[HALT] = op == 3'd0; end
      4'd5: r[RD] = alu;
      4'd6: begin r[RD] = alu; r[INC] = op == 3'd1 && z; r[LDPC] = op == 3'd7; r[DE] = op == 3'd6; end
      4'd7: begin r[RD] = alu; r[LDA] = alu; r[LDPC] = op == 3'd7; r[WR] = op == 3'd6; r[DE] = op == 3'd6; end
      4'd9: r[HALT] = 1'b1;
      default: r = '0;
    endcase
    if (st < 4'd8) begin r[BUSY] = 1'b1; r[11:9] = st[2:0]; end
    return r;
  endfunction

  always @(negedge clk or posedge probe)
    if (vq.size() > 0) begin
      exp_v = vq.pop_front();
      exp_n = nq.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s got %b exp %b (busy,phase,halt,sel,rd,ld_ir,inc_pc,ld_pc,ld_acc,wr,data_e)",
                 exp_n, got, exp_v);
      end
    end

  task automatic push(input string n, input logic [12:0] e);
    nq.push_back(n);
    vq.push_back(e);
  endtask

  task automatic cyc(input string n, input logic [12:0] e);
    push(n, e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [2:0] op, input logic z, input int sp, input int last);
    for (int p = 0; p <= last; p++) begin
      opcode = op;
      zero = z;
      start = (p == sp);
      cyc($sformatf("op%0d_z%0d_p%0d", op, z, p), ev(p[3:0], op, z));
    end
    start = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc("in_reset", ev(4'd8, 3'd0, 1'b0));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc("stopped_idle", ev(4'd8, 3'd0, 1'b0));
    start = 1'b1;
    cyc("start_sampled", ev(4'd8, 3'd0, 1'b0));
    start = 1'b0;
    run(3'd2, 1'b0, -1, 7);
    run(3'd2, 1'b1, -1, 7);
    run(3'd1, 1'b1, -1, 7);
    run(3'd1, 1'b0, -1, 7);
    run(3'd7, 1'b0, -1, 7);
    run(3'd6, 1'b0, -1, 7);
    run(3'd3, 1'b0, -1, 7);
    run(3'd4, 1'b1, -1, 7);
    run(3'd5, 1'b0, 2, 7);
    run(3'd0, 1'b0, -1, 4);
    for (int i = 0; i < 10; i++) cyc("halted", ev(4'd9, 3'd0, 1'b0));
    start = 1'b1;
    cyc("halted_start", ev(4'd9, 3'd0, 1'b0));
    start = 1'b0;
    run(3'd6, 1'b0, -1, 5);
    push("sto_p6_pre_rst", ev(4'd6, 3'd6, 1'b0));
    @(negedge clk);
    #2;
    rst = 1'b1;
    start = 1'b1;
    #1;
    push("async_rst_mid_p6", ev(4'd8, 3'd0, 1'b0));
    probe = 1'b1;
    #1;
    probe = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc("rst_over_start", ev(4'd8, 3'd0, 1'b0));
    rst = 1'b0;
    cyc("rst_release", ev(4'd8, 3'd0, 1'b0));
    start = 1'b0;
    run(3'd2, 1'b0, -1, 7);
    run(3'd5, 1'b1, -1, 3);
    for (int i = 0; i < 4 && vq.size() > 0; i++) @(negedge clk);
    if (vq.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", vq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
